// File: rtl/latch_reader.sv
// Read-back for the SR-latch bit-cell array: sync, snapshot, serialise.
// Reports the snapshot's all-zero flag and population count.
module latch_reader #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             q,
  input  logic                     start,
  input  logic                     ready,
  output logic                     dout,
  output logic                     valid,
  output logic                     last,
  output logic                     busy,
  output logic                     done,
  output logic                     is0,
  output logic [$clog2(N+1)-1:0]   ones
);

  localparam int IW = $clog2(N);
  localparam int OW = $clog2(N+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  logic [1:0]    state;
  logic [N-1:0]  q_s1;
  logic [N-1:0]  q_s2;
  logic [N-1:0]  snap;
  logic [IW-1:0] idx;
  logic [OW-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + OW'(q_s2[i]);
    end
  end

  // Outputs decode straight from state so reset clears them on one edge
  assign valid = (state == SHIFT);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign last  = valid && (idx == LAST_IDX);
  assign dout  = valid && snap[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q_s1  <= '0;
      q_s2  <= '0;
      snap  <= '0;
      idx   <= '0;
      is0   <= 1'b0;
      ones  <= '0;
    end else begin
      q_s1 <= q;
      q_s2 <= q_s1;
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= q_s2;
            idx   <= '0;
            is0   <= (q_s2 == '0);
            ones  <= pop;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ready) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_reader.sv
// Bench for latch_reader: directed frame table, corner sequences,
// and random traffic against a cycle-level behavioural model.
module tb_latch_reader;

  localparam int N  = 8;
  localparam int OW = $clog2(N+1);

  logic          clk;
  logic          reset;
  logic [N-1:0]  q;
  logic          start;
  logic          ready;
  logic          dout;
  logic          valid;
  logic          last;
  logic          busy;
  logic          done;
  logic          is0;
  logic [OW-1:0] ones;

  latch_reader #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .start (start),
    .ready (ready),
    .dout  (dout),
    .valid (valid),
    .last  (last),
    .busy  (busy),
    .done  (done),
    .is0   (is0),
    .ones  (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: sync history, frame position (-1 = none), done flag
  logic [N-1:0] m_s1, m_s2, m_snap;
  int           m_pos = -1;
  bit           m_done = 0;
  bit           m_is0 = 0;
  int           m_ones = 0;
  bit           chk_en = 0;

  int           nx;
  logic [N-1:0] xb;
  int           ndone;
  int           done_at;
  int           cyc_no;

  typedef struct {
    logic [7:0] qv;
    bit         bp;
    logic [7:0] eb;
    int         eones;
    bit         eis0;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_snap = '0;
      m_pos = -1; m_done = 0; m_is0 = 0; m_ones = 0;
      chk_en = 1;
    end else begin
      if (m_done) begin
        m_done = 0;
      end else if (m_pos >= 0) begin
        if (ready) begin
          if (m_pos == N-1) begin
            m_pos = -1;
            m_done = 1;
          end else begin
            m_pos++;
          end
        end
      end else if (start) begin
        m_snap = m_s2;
        m_is0  = (m_s2 == '0);
        m_ones = $countones(m_s2);
        m_pos  = 0;
      end
      m_s2 = m_s1;
      m_s1 = q;
    end
  endtask

  task automatic cyc();
    logic [9:0] got, exp;
    logic       ev;
    @(negedge clk);
    if (chk_en) begin
      ev  = (m_pos >= 0);
      exp = {ev ? m_snap[m_pos] : 1'b0, ev, (m_pos == N-1),
             ev || m_done, m_done, m_is0, OW'(m_ones)};
      got = {dout, valid, last, busy, done, is0, ones};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model t=%0t got %b exp %b", $time, got, exp);
      end
    end
    if (valid === 1'b1 && ready) begin
      if (nx < N) xb[nx] = dout;
      nx++;
    end
    if (done === 1'b1) begin
      ndone++;
      done_at = cyc_no;
    end
    @(posedge clk);
    model_step();
    cyc_no++;
    #1;
  endtask

  task automatic hold_q(input logic [N-1:0] v);
    q = v;
    start = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic fire();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc_no = 1;
    nx = 0;
    xb = '0;
    ndone = 0;
    done_at = -1;
  endtask

  task automatic check_frame(input string nm, input logic [7:0] eb,
                             input int eones, input bit eis0, input bit bp);
    for (int i = 0; i < 40 && ndone == 0; i++) begin
      ready = bp ? i[0] : 1'b1;
      cyc();
    end
    ready = 1'b1;
    chk({nm, "_done"}, ndone, 1);
    chk({nm, "_xfers"}, nx, N);
    chk({nm, "_bits"}, int'(xb), int'(eb));
    chk({nm, "_ones"}, int'(ones), eones);
    chk({nm, "_is0"}, int'(is0), int'(eis0));
    if (!bp) chk({nm, "_done_cyc"}, done_at, N+1);
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{qv: 8'hA5, bp: 0, eb: 8'hA5, eones: 4, eis0: 0};
    tbl[1] = '{qv: 8'h81, bp: 1, eb: 8'h81, eones: 2, eis0: 0};
    tbl[2] = '{qv: 8'h00, bp: 0, eb: 8'h00, eones: 0, eis0: 1};
    tbl[3] = '{qv: 8'hFF, bp: 0, eb: 8'hFF, eones: 8, eis0: 0};
    tbl[4] = '{qv: 8'h5A, bp: 1, eb: 8'h5A, eones: 4, eis0: 0};

    reset = 1'b1;
    q = '0;
    start = 1'b0;
    ready = 1'b0;
    nx = 0; ndone = 0; cyc_no = 0; done_at = -1; xb = '0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("reset_state", int'({dout, valid, last, busy, done, is0, ones}), 0);

    foreach (tbl[i]) begin
      hold_q(tbl[i].qv);
      ready = 1'b1;
      fire();
      check_frame($sformatf("tbl%0d", i), tbl[i].eb, tbl[i].eones,
                  tbl[i].eis0, tbl[i].bp);
    end

    // Reset in cycle 4 of an all-ones frame
    hold_q(8'hFF);
    ready = 1'b1;
    fire();
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midreset_outs",
        int'({dout, valid, last, busy, done, is0, ones}), 0);
    ndone = 0;
    repeat (12) cyc();
    chk("midreset_nodone", ndone, 0);
    hold_q(8'h0F);
    fire();
    check_frame("after_reset", 8'h0F, 4, 0, 0);

    // start pulses in SHIFT and DONE, q change mid-frame
    hold_q(8'h3C);
    ready = 1'b1;
    fire();
    for (int k = 1; k <= 11; k++) begin
      q = (k >= 2) ? 8'hC3 : 8'h3C;
      start = (k == 3 || k == 9);
      cyc();
    end
    start = 1'b0;
    chk("ign_xfers", nx, N);
    chk("ign_bits", int'(xb), 8'h3C);
    chk("ign_ones", int'(ones), 4);
    chk("ign_ndone", ndone, 1);
    chk("ign_done_cyc", done_at, N+1);
    chk("ign_idle", int'(busy), 0);

    // q change one edge before start: old value captured
    hold_q(8'h00);
    q = 8'h01;
    cyc();
    fire();
    check_frame("sync1", 8'h00, 0, 1, 0);

    // q change two edges before start: new value captured
    hold_q(8'h00);
    q = 8'h01;
    repeat (2) cyc();
    fire();
    check_frame("sync2", 8'h01, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      q     = N'($urandom);
      start = ($urandom_range(0, 3) == 0);
      ready = $urandom_range(0, 1) == 1;
      reset = ($urandom_range(0, 63) == 0);
      cyc();
    end
    reset = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    repeat (N + 4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
